// File: rtl/mavg_pkg.sv
// Shared definitions for the moving-sum filter family.
//   WIN    : window length (taps)
//   DW     : unsigned sample width
//   SW     : unsigned window-sum width (SW >= DW + clog2(WIN))
//   clog2  : ceiling log2 helper for constant expressions
//   sat_u  : clamp a signed value into the unsigned range 0..2^dw-1
package mavg_pkg;

  localparam int unsigned WIN = 5;
  localparam int unsigned DW  = 8;
  localparam int unsigned SW  = 11;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Narrowest sum width that can hold WIN full-scale samples.
  localparam int unsigned SW_MIN = DW + clog2(WIN);

  // Result is returned in 32 bits; callers size-cast to their sample width.
  function automatic logic [31:0] sat_u(input logic signed [31:0] x,
                                        input int unsigned       dw);
    logic signed [31:0] maxv;
    maxv = (32'sd1 <<< dw) - 32'sd1;
    if (x < 32'sd0) begin
      return '0;
    end else if (x > maxv) begin
      return maxv;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/mavg_hist_sr.sv
// Recovered-sample history: WIN-deep shift register of DW-bit samples.
//   clock    : system clock, rising edge
//   reset    : asynchronous active-low reset, clears all entries
//   clr      : synchronous clear of all entries (wins over shift_en)
//   shift_en : push din into entry 0, older entries move toward the tail
//   din      : sample to push
//   tail     : oldest entry, hist[WIN-1]
module mavg_hist_sr
  import mavg_pkg::*;
#(
  parameter int unsigned WIN = mavg_pkg::WIN,
  parameter int unsigned DW  = mavg_pkg::DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          shift_en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] tail
);

  logic [DW-1:0] hist [WIN];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist <= '{default: '0};
    end else if (clr) begin
      hist <= '{default: '0};
    end else if (shift_en) begin
      hist[0] <= din;
      for (int unsigned i = 1; i < WIN; i++) begin
        hist[i] <= hist[i-1];
      end
    end
  end

  assign tail = hist[WIN-1];

endmodule

// File: rtl/mavg_inverse.sv
// Inverse of the WIN-tap moving-sum stage: recovers x[n] from window sums
// using x[n] = S[n] - S[n-1] + x[n-WIN]. Two-stage pipeline, vin -> vout
// latency of two clocks, one sample per clock, no backpressure.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   clr   : synchronous clear of all state (dout holds), wins over vin
//   vin   : din valid
//   din   : window sum S[n], SW bits unsigned
//   vout  : dout valid, one pulse per accepted vin
//   dout  : recovered sample x[n], saturated to DW bits
//   err   : sticky flag, set when any x[n] fell outside 0..2^DW-1
//   err_p : one-cycle error pulse aligned with the offending vout
module mavg_inverse
  import mavg_pkg::*;
#(
  parameter int unsigned WIN = mavg_pkg::WIN,
  parameter int unsigned DW  = mavg_pkg::DW,
  parameter int unsigned SW  = mavg_pkg::SW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          vin,
  input  logic [SW-1:0] din,
  output logic          vout,
  output logic [DW-1:0] dout,
  output logic          err,
  output logic          err_p
);

  // Stage 1 state
  logic [SW-1:0]      s_prev;
  logic signed [SW:0] diff_r;
  logic               v1;

  // Stage 2 datapath
  logic [DW-1:0]        hist_tail;
  logic signed [SW+1:0] x;
  logic [DW-1:0]        x_sat;
  logic                 x_oor;

  // Stage 1: first difference of the incoming sums.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_prev <= '0;
      diff_r <= '0;
      v1     <= 1'b0;
    end else if (clr) begin
      s_prev <= '0;
      v1     <= 1'b0;
    end else begin
      v1 <= vin;
      if (vin) begin
        diff_r <= $signed({1'b0, din}) - $signed({1'b0, s_prev});
        s_prev <= din;
      end
    end
  end

  // Stage 2: add back the sample that left the window, then clamp.
  always_comb begin
    x     = (SW+2)'(diff_r) + $signed({2'b00, {(SW-DW){1'b0}}, hist_tail});
    // Negative shows as the sign bit; too large shows as any bit above DW.
    x_oor = x[SW+1] | (|x[SW:DW]);
    x_sat = DW'(sat_u(32'(x), DW));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vout  <= 1'b0;
      dout  <= '0;
      err   <= 1'b0;
      err_p <= 1'b0;
    end else if (clr) begin
      vout  <= 1'b0;
      err   <= 1'b0;
      err_p <= 1'b0;
    end else begin
      vout  <= v1;
      err_p <= v1 & x_oor;
      if (v1) begin
        dout <= x_sat;
        err  <= err | x_oor;
      end
    end
  end

  // The clamped value is what enters the history, so a range error
  // cannot keep feeding back into later samples.
  mavg_hist_sr #(
    .WIN (WIN),
    .DW  (DW)
  ) u_hist (
    .clock    (clock),
    .reset    (reset),
    .clr      (clr),
    .shift_en (v1 & ~clr),
    .din      (x_sat),
    .tail     (hist_tail)
  );

endmodule
